can_cpu_bus_arbiter: RTL and testbench
======================================

Name: can_cpu_bus_arbiter

Overview:
- Two-master arbiter for the single CPU register port of CAN_Top (cpu_cs/read/write/addr/wdat/rdat/ack/err).
- Lets the init/TX sequencer (m0) and a separate RX-drain or host-bridge master (m1) share the controller without bus collisions.
- Arbitration is round-robin. Each transfer is latched and then guarded by an ack-timeout watchdog.
- Every transfer is terminated back to its requester with a one-cycle ack or err pulse.

Parameters:
- TIMEOUT_CYC, default 255: number of cpu_cs-high cycles without cpu_ack/cpu_err before the transfer is forced to an error. Legal range 1..2^TO_W-1.
- TO_W, default 8: width of the timeout counter.

Ports:
- sysclk in 1: system clock.
- ponrst_n in 1: asynchronous active-low reset.
- m0_cs in 1: master 0 request; held until m0_ack or m0_err.
- m0_write in 1: master 0 write op.
- m0_read in 1: master 0 read op.
- m0_addr in 32: master 0 register address.
- m0_wdat in 32: master 0 write data.
- m0_rdat out 32: master 0 read data, valid with m0_ack.
- m0_ack out 1: master 0 one-cycle completion pulse.
- m0_err out 1: master 0 one-cycle error pulse.
- m1_cs, m1_write, m1_read, m1_addr, m1_wdat, m1_rdat, m1_ack, m1_err: same as m0_* for master 1.
- cpu_cs out 1: to CAN_Top.
- cpu_write out 1: to CAN_Top.
- cpu_read out 1: to CAN_Top.
- cpu_addr out 32: to CAN_Top.
- cpu_wdat out 32: to CAN_Top.
- cpu_rdat in 32: from CAN_Top.
- cpu_ack in 1: from CAN_Top.
- cpu_err in 1: from CAN_Top.
- grant out 2: one-hot owner of the current transfer; 0 when not BUSY.
- timeout_o out 1: one-cycle pulse when the watchdog fires.

Behaviour:
- Interface: reset ponrst_n, asynchronous, active-low; clock sysclk. All outputs are registered.
- Reset values: every output 0. State = IDLE. last_grant = 1, so m0 wins the first tie. Timeout counter = 0.
- Requester protocol:
  - Assert mX_cs with exactly one of mX_write/mX_read.
  - Hold addr/wdat until the ack/err pulse.
  - Deassert cs no later than the edge after the pulse.
- State IDLE:
  - Sample m0_cs and m1_cs. None set: stay IDLE.
  - One valid request: select it. Both set: select the master not equal to last_grant.
  - Valid selection, at the edge: latch op/addr/wdat into cpu_*, set cpu_cs=1, grant=one-hot, timeout counter=0, go to BUSY.
  - Invalid op on the selected master (read==write): do not touch the cpu bus. Set mX_err=1, update last_grant, go to DONE.
- State BUSY:
  - cpu_* hold their latched values. Changes on mX inputs are ignored.
  - cpu_ack=1: at the edge, cpu_cs/read/write=0, mX_rdat<=cpu_rdat if read (writes leave mX_rdat unchanged), mX_ack=1, grant=0, last_grant<=owner, go to DONE.
  - cpu_err=1 with cpu_ack=0: same as cpu_ack, but mX_err=1 and mX_ack stays 0.
  - Neither ack nor err: counter increments. If counter==TIMEOUT_CYC-1 at that edge, terminate as an error with timeout_o=1. cpu_cs is therefore high exactly TIMEOUT_CYC cycles.
  - cpu_ack or cpu_err in the same cycle as the timeout: the bus response wins and timeout_o stays 0.
- State DONE (one cycle):
  - All pulses clear at the exit edge. Go to IDLE.
  - This guarantees the requester's cs drop is seen before re-arbitration. Minimum IDLE-to-IDLE turnaround is 3 cycles plus ack latency.
- cpu_ack or cpu_err while IDLE or DONE: ignored, no output change.
- Requester drops cs mid-BUSY: no abort. The transfer completes and the pulse is still issued.
- cpu_addr and cpu_wdat return to 0 when leaving BUSY. cpu_wdat is 0 for reads.
- ponrst_n low in any state: asynchronous return to reset values. A pending transfer is discarded without any pulse.

Test Plan:
- Write path: m0 write addr 0x0008 data 0x0000000A; CAN acks after 3 BUSY cycles. Required: cpu_cs high 3 cycles with addr/wdat stable, one m0_ack pulse, m1_* stay 0, grant=01 during BUSY.
- Tie after reset: m0 write 0x0040/0x00030000 and m1 read 0x0200 asserted on the same cycle; m1 read returns cpu_rdat=0x12345678. Required: m0 served first, then m1; m1_rdat=0x12345678 with m1_ack; no cpu_cs overlap.
- Fairness: both masters re-request immediately after each pulse for 6 transfers. Required: grant sequence 01,10,01,10,01,10, with one DONE cycle between transfers.
- Watchdog: TIMEOUT_CYC=16, m0 write, no cpu_ack. Required: cpu_cs high exactly 16 cycles, m0_err and timeout_o pulse together, m0_ack=0. The next m1 request is then served normally.
- Invalid op: m1_cs with m1_read=m1_write=1. Required: m1_err pulse on the cycle after sampling, cpu_cs never asserted, last_grant=m1.
- Reset mid-transfer: ponrst_n low in the 2nd BUSY cycle. Required: cpu_cs and all outputs 0 immediately, no pulse. After release with both requesting, m0 is granted first.

Source files
------------

// File: rtl/can_cpu_bus_arbiter_if.sv
// Register-port bundle shared by the two requesters and the CAN_Top CPU port.
// The master modport drives a request; the slave modport answers it.
interface can_cpu_bus_arbiter_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (output cs, write, read, addr, wdat, input rdat, ack, err);
    modport slave  (input cs, write, read, addr, wdat, output rdat, ack, err);
endinterface

// File: rtl/can_cpu_bus_arbiter.sv
// Round-robin two-master arbiter for the CAN_Top CPU register port.
// Each granted transfer is latched onto the bus and guarded by an ack-timeout watchdog.
module can_cpu_bus_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int TO_W        = 8
) (
    input  logic                  sysclk,
    input  logic                  ponrst_n,
    can_cpu_bus_arbiter_if.slave  m0,
    can_cpu_bus_arbiter_if.slave  m1,
    can_cpu_bus_arbiter_if.master cpu,
    output logic [1:0]            grant,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_reg, state_next;
    logic            last_grant_reg, last_grant_next;   // 1 = master 1 was served last
    logic            owner_reg, owner_next;
    logic [TO_W-1:0] cnt_reg, cnt_next;
    logic            cpu_cs_reg, cpu_cs_next;
    logic            cpu_write_reg, cpu_write_next;
    logic            cpu_read_reg, cpu_read_next;
    logic [31:0]     cpu_addr_reg, cpu_addr_next;
    logic [31:0]     cpu_wdat_reg, cpu_wdat_next;
    logic [1:0]      grant_reg, grant_next;
    logic            timeout_reg, timeout_next;
    logic [1:0]      ack_reg, ack_next;
    logic [1:0]      err_reg, err_next;
    logic [31:0]     rdat_reg  [2];
    logic [31:0]     rdat_next [2];

    logic [1:0]      req_cs, req_write, req_read;
    logic [31:0]     req_addr [2];
    logic [31:0]     req_wdat [2];
    logic            sel;
    logic            finish;

    assign req_cs      = {m1.cs, m0.cs};
    assign req_write   = {m1.write, m0.write};
    assign req_read    = {m1.read, m0.read};
    assign req_addr[0] = m0.addr;
    assign req_addr[1] = m1.addr;
    assign req_wdat[0] = m0.wdat;
    assign req_wdat[1] = m1.wdat;

    always_ff @(posedge sysclk or negedge ponrst_n) begin
        if (!ponrst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            cpu_cs_reg     <= 1'b0;
            cpu_write_reg  <= 1'b0;
            cpu_read_reg   <= 1'b0;
            cpu_addr_reg   <= '0;
            cpu_wdat_reg   <= '0;
            grant_reg      <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            cpu_cs_reg     <= cpu_cs_next;
            cpu_write_reg  <= cpu_write_next;
            cpu_read_reg   <= cpu_read_next;
            cpu_addr_reg   <= cpu_addr_next;
            cpu_wdat_reg   <= cpu_wdat_next;
            grant_reg      <= grant_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Per-requester response registers
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        always_ff @(posedge sysclk or negedge ponrst_n) begin
            if (!ponrst_n) begin
                ack_reg[gi]  <= 1'b0;
                err_reg[gi]  <= 1'b0;
                rdat_reg[gi] <= '0;
            end else begin
                ack_reg[gi]  <= ack_next[gi];
                err_reg[gi]  <= err_next[gi];
                rdat_reg[gi] <= rdat_next[gi];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        cpu_cs_next     = cpu_cs_reg;
        cpu_write_next  = cpu_write_reg;
        cpu_read_next   = cpu_read_reg;
        cpu_addr_next   = cpu_addr_reg;
        cpu_wdat_next   = cpu_wdat_reg;
        grant_next      = grant_reg;
        timeout_next    = timeout_reg;
        ack_next        = ack_reg;
        err_next        = err_reg;
        rdat_next[0]    = rdat_reg[0];
        rdat_next[1]    = rdat_reg[1];
        sel             = 1'b0;
        finish          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req_cs) begin
                    sel = (&req_cs) ? ~last_grant_reg : req_cs[1];
                    if (req_write[sel] ^ req_read[sel]) begin
                        cpu_cs_next    = 1'b1;
                        cpu_write_next = req_write[sel];
                        cpu_read_next  = req_read[sel];
                        cpu_addr_next  = req_addr[sel];
                        cpu_wdat_next  = req_write[sel] ? req_wdat[sel] : 32'd0;
                        grant_next     = sel ? 2'b10 : 2'b01;
                        owner_next     = sel;
                        cnt_next       = '0;
                        state_next     = BUSY;
                    end else begin
                        // Malformed op is refused without touching the CAN bus
                        err_next[sel]   = 1'b1;
                        last_grant_next = sel;
                        state_next      = DONE;
                    end
                end
            end

            BUSY: begin
                if (cpu.ack || cpu.err) begin
                    finish = 1'b1;
                    if (cpu.ack) begin
                        ack_next[owner_reg] = 1'b1;
                        if (cpu_read_reg) rdat_next[owner_reg] = cpu.rdat;
                    end else begin
                        err_next[owner_reg] = 1'b1;
                    end
                end else if (cnt_reg == TO_LAST) begin
                    finish              = 1'b1;
                    err_next[owner_reg] = 1'b1;
                    timeout_next        = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end

                if (finish) begin
                    cpu_cs_next     = 1'b0;
                    cpu_write_next  = 1'b0;
                    cpu_read_next   = 1'b0;
                    cpu_addr_next   = '0;
                    cpu_wdat_next   = '0;
                    grant_next      = '0;
                    last_grant_next = owner_reg;
                    state_next      = DONE;
                end
            end

            DONE: begin
                // One dead cycle lets the requester drop cs before re-arbitration
                ack_next     = '0;
                err_next     = '0;
                timeout_next = 1'b0;
                state_next   = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    assign cpu.cs    = cpu_cs_reg;
    assign cpu.write = cpu_write_reg;
    assign cpu.read  = cpu_read_reg;
    assign cpu.addr  = cpu_addr_reg;
    assign cpu.wdat  = cpu_wdat_reg;
    assign m0.ack    = ack_reg[0];
    assign m0.err    = err_reg[0];
    assign m0.rdat   = rdat_reg[0];
    assign m1.ack    = ack_reg[1];
    assign m1.err    = err_reg[1];
    assign m1.rdat   = rdat_reg[1];
    assign grant     = grant_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_can_cpu_bus_arbiter.sv
// Directed bench for can_cpu_bus_arbiter: CAN responder and requester models,
// a bus monitor, and one task per scenario with inline expected-value checks.
module tb_can_cpu_bus_arbiter;

    logic       sysclk = 1'b0;
    logic       ponrst_n;
    logic [1:0] grant;
    logic       timeout_o;

    can_cpu_bus_arbiter_if m0 ();
    can_cpu_bus_arbiter_if m1 ();
    can_cpu_bus_arbiter_if cpu ();

    can_cpu_bus_arbiter #(.TIMEOUT_CYC(16), .TO_W(8)) dut (
        .sysclk    (sysclk),
        .ponrst_n  (ponrst_n),
        .m0        (m0),
        .m1        (m1),
        .cpu       (cpu),
        .grant     (grant),
        .timeout_o (timeout_o)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // CAN_Top model: mode 0 acks, 1 errors, 2 never answers; answers on the resp_lat-th cs cycle
    int          resp_mode = 0;
    int          resp_lat  = 3;
    int          resp_cnt  = 0;
    logic [31:0] resp_rdat = 32'd0;
    always @(negedge sysclk) begin
        if (cpu.cs === 1'b1) begin
            resp_cnt++;
            cpu.ack = (resp_mode == 0) && (resp_cnt == resp_lat);
            cpu.err = (resp_mode == 1) && (resp_cnt == resp_lat);
        end else begin
            resp_cnt = 0;
            cpu.ack  = 1'b0;
            cpu.err  = 1'b0;
        end
        cpu.rdat = resp_rdat;
    end

    // Requesters keep cs up until their remaining transfer count reaches zero
    int m0_left = 0;
    int m1_left = 0;
    always @(negedge sysclk) begin
        if (m0.ack === 1'b1 || m0.err === 1'b1) begin
            m0_left--;
            if (m0_left <= 0) m0.cs = 1'b0;
        end
        if (m1.ack === 1'b1 || m1.err === 1'b1) begin
            m1_left--;
            if (m1_left <= 0) m1.cs = 1'b0;
        end
    end

    // Bus monitor
    logic        prev_cs = 1'b0;
    int          cs_len = 0, gap = 0, started = 0, unstable = 0;
    int          a0 = 0, e0 = 0, a1 = 0, e1 = 0, to_cnt = 0, to_with_err = 0;
    logic [1:0]  grant_q [$];
    int          len_q [$];
    int          gap_q [$];
    logic [31:0] addr_q [$];
    logic [31:0] wdat_q [$];
    logic [31:0] cur_addr, cur_wdat, m1_rdat_at_ack;
    logic [1:0]  cur_grant;
    always @(negedge sysclk) begin
        if (cpu.cs === 1'b1) begin
            if (!prev_cs) begin
                grant_q.push_back(grant);
                addr_q.push_back(cpu.addr);
                wdat_q.push_back(cpu.wdat);
                cur_addr  = cpu.addr;
                cur_wdat  = cpu.wdat;
                cur_grant = grant;
                cs_len    = 0;
                if (started != 0) gap_q.push_back(gap);
                started = 1;
            end else if (cpu.addr !== cur_addr || cpu.wdat !== cur_wdat || grant !== cur_grant) begin
                unstable++;
            end
            cs_len++;
        end else begin
            if (prev_cs) begin
                len_q.push_back(cs_len);
                $display("xfer grant=%b addr=%h wdat=%h cs_cycles=%0d", cur_grant, cur_addr, cur_wdat, cs_len);
                gap = 0;
            end
            gap++;
        end
        prev_cs = (cpu.cs === 1'b1);
        if (m0.ack === 1'b1) a0++;
        if (m0.err === 1'b1) e0++;
        if (m1.ack === 1'b1) begin a1++; m1_rdat_at_ack = m1.rdat; end
        if (m1.err === 1'b1) e1++;
        if (timeout_o === 1'b1) begin
            to_cnt++;
            if (m0.err === 1'b1 || m1.err === 1'b1) to_with_err++;
        end
    end

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic clear_mon();
        grant_q.delete(); len_q.delete(); gap_q.delete(); addr_q.delete(); wdat_q.delete();
        started = 0; gap = 0; unstable = 0;
        a0 = 0; e0 = 0; a1 = 0; e1 = 0; to_cnt = 0; to_with_err = 0;
        m1_rdat_at_ack = 32'd0;
    endtask

    task automatic wait_pulses(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (a0 + e0 + a1 + e1 >= n) break;
            tick();
        end
        ok = (a0 + e0 + a1 + e1 >= n);
        repeat (3) tick();
    endtask

    task automatic set_m0(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdat, input int n);
        m0.write = wr; m0.read = rd; m0.addr = addr; m0.wdat = wdat; m0_left = n;
    endtask

    task automatic set_m1(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdat, input int n);
        m1.write = wr; m1.read = rd; m1.addr = addr; m1.wdat = wdat; m1_left = n;
    endtask

    task automatic apply_reset();
        ponrst_n = 1'b0;
        m0.cs = 1'b0; m0.write = 1'b0; m0.read = 1'b0; m0.addr = '0; m0.wdat = '0;
        m1.cs = 1'b0; m1.write = 1'b0; m1.read = 1'b0; m1.addr = '0; m1.wdat = '0;
        cpu.ack = 1'b0; cpu.err = 1'b0; cpu.rdat = '0;
        m0_left = 0; m1_left = 0;
        repeat (2) tick();
        ponrst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        ponrst_n = 1'b0;
        m0.cs = 1'b0; m1.cs = 1'b0; cpu.ack = 1'b0; cpu.err = 1'b0;
        #2;
        checks++; if (cpu.cs !== 1'b0 || cpu.write !== 1'b0 || cpu.read !== 1'b0) begin errors++; $display("FAIL reset_cpu_ctrl: cs/wr/rd=%b%b%b want 000", cpu.cs, cpu.write, cpu.read); end
        checks++; if (cpu.addr !== 32'd0 || cpu.wdat !== 32'd0) begin errors++; $display("FAIL reset_cpu_data: addr=%h wdat=%h want 0", cpu.addr, cpu.wdat); end
        checks++; if (grant !== 2'b00 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_grant_to: grant=%b to=%b want 00/0", grant, timeout_o); end
        checks++; if ({m0.ack, m0.err, m1.ack, m1.err} !== 4'b0 || m0.rdat !== 32'd0 || m1.rdat !== 32'd0) begin errors++; $display("FAIL reset_masters: pulses=%b m0_rdat=%h m1_rdat=%h want 0", {m0.ack, m0.err, m1.ack, m1.err}, m0.rdat, m1.rdat); end
        apply_reset();
        clear_mon();
        // Stray bus response while idle must be ignored
        cpu.ack = 1'b1; cpu.err = 1'b1;
        repeat (3) tick();
        checks++; if (cpu.cs !== 1'b0 || grant !== 2'b00 || a0 + e0 + a1 + e1 != 0) begin errors++; $display("FAIL idle_stray_ack: cs=%b grant=%b pulses=%0d want 0", cpu.cs, grant, a0 + e0 + a1 + e1); end
    endtask

    task automatic test_write_path();
        bit ok;
        clear_mon();
        resp_mode = 0; resp_lat = 3;
        set_m0(1'b1, 1'b0, 32'h0000_0008, 32'h0000_000A, 1);
        m0.cs = 1'b1;
        wait_pulses(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_done: no pulse within budget"); end
        checks++; if (len_q.size() != 1 || len_q[0] != 3) begin errors++; $display("FAIL wr_cs_len: xfers=%0d len=%0d want 1/3", len_q.size(), len_q[0]); end
        checks++; if (grant_q[0] !== 2'b01 || addr_q[0] !== 32'h8 || wdat_q[0] !== 32'hA) begin errors++; $display("FAIL wr_bus: grant=%b addr=%h wdat=%h want 01/8/a", grant_q[0], addr_q[0], wdat_q[0]); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL wr_stable: unstable=%0d want 0", unstable); end
        checks++; if (a0 != 1 || e0 != 0 || a1 + e1 != 0 || m1.rdat !== 32'd0) begin errors++; $display("FAIL wr_pulses: a0=%0d e0=%0d m1=%0d want 1/0/0", a0, e0, a1 + e1); end
        checks++; if (cpu.addr !== 32'd0 || cpu.wdat !== 32'd0 || grant !== 2'b00) begin errors++; $display("FAIL wr_after: addr=%h wdat=%h grant=%b want 0", cpu.addr, cpu.wdat, grant); end
    endtask

    task automatic test_tie_after_reset();
        bit ok;
        apply_reset();
        clear_mon();
        resp_mode = 0; resp_lat = 2; resp_rdat = 32'h1234_5678;
        set_m0(1'b1, 1'b0, 32'h0000_0040, 32'h0003_0000, 1);
        set_m1(1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1);
        m0.cs = 1'b1; m1.cs = 1'b1;
        wait_pulses(2, 80, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tie_done: pulses=%0d want 2", a0 + e0 + a1 + e1); end
        checks++; if (grant_q.size() != 2 || grant_q[0] !== 2'b01 || grant_q[1] !== 2'b10) begin errors++; $display("FAIL tie_order: n=%0d g0=%b g1=%b want 2/01/10", grant_q.size(), grant_q[0], grant_q[1]); end
        checks++; if (addr_q[1] !== 32'h200 || wdat_q[1] !== 32'd0 || wdat_q[0] !== 32'h0003_0000) begin errors++; $display("FAIL tie_bus: a1=%h w1=%h w0=%h want 200/0/30000", addr_q[1], wdat_q[1], wdat_q[0]); end
        checks++; if (m1_rdat_at_ack !== 32'h1234_5678 || m1.rdat !== 32'h1234_5678 || a1 != 1) begin errors++; $display("FAIL tie_rdat: at_ack=%h now=%h a1=%0d want 12345678", m1_rdat_at_ack, m1.rdat, a1); end
        checks++; if (m0.rdat !== 32'd0 || a0 != 1) begin errors++; $display("FAIL tie_m0: rdat=%h a0=%0d want 0/1", m0.rdat, a0); end
        checks++; if (gap_q.size() != 1 || gap_q[0] != 2) begin errors++; $display("FAIL tie_gap: n=%0d gap=%0d want 1/2", gap_q.size(), gap_q[0]); end
    endtask

    task automatic test_fairness();
        bit ok;
        logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        clear_mon();
        resp_mode = 0; resp_lat = 1;
        set_m0(1'b1, 1'b0, 32'h10, 32'h55, 3);
        set_m1(1'b0, 1'b1, 32'h20, 32'h0, 3);
        m0.cs = 1'b1; m1.cs = 1'b1;
        wait_pulses(6, 200, ok);
        checks++; if (!ok || grant_q.size() != 6) begin errors++; $display("FAIL fair_count: xfers=%0d want 6", grant_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (grant_q[i] !== exp_g[i]) begin errors++; $display("FAIL fair_grant%0d: grant=%b want %b", i, grant_q[i], exp_g[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (gap_q[i] != 2) begin errors++; $display("FAIL fair_gap%0d: gap=%0d want 2", i, gap_q[i]); end
        end
        checks++; if (a0 != 3 || a1 != 3) begin errors++; $display("FAIL fair_acks: a0=%0d a1=%0d want 3/3", a0, a1); end
    endtask

    task automatic test_watchdog();
        bit ok;
        clear_mon();
        resp_mode = 2;
        set_m0(1'b1, 1'b0, 32'h80, 32'h1, 1);
        m0.cs = 1'b1;
        wait_pulses(1, 60, ok);
        checks++; if (!ok || len_q.size() != 1 || len_q[0] != 16) begin errors++; $display("FAIL wd_len: len=%0d want 16", len_q[0]); end
        checks++; if (e0 != 1 || a0 != 0) begin errors++; $display("FAIL wd_pulse: e0=%0d a0=%0d want 1/0", e0, a0); end
        checks++; if (to_cnt != 1 || to_with_err != 1) begin errors++; $display("FAIL wd_timeout: to=%0d with_err=%0d want 1/1", to_cnt, to_with_err); end
        clear_mon();
        resp_mode = 0; resp_lat = 2; resp_rdat = 32'hCAFE_F00D;
        set_m1(1'b0, 1'b1, 32'h300, 32'h0, 1);
        m1.cs = 1'b1;
        wait_pulses(1, 40, ok);
        checks++; if (!ok || a1 != 1 || grant_q[0] !== 2'b10 || m1.rdat !== 32'hCAFE_F00D || to_cnt != 0) begin errors++; $display("FAIL wd_next: a1=%0d grant=%b rdat=%h to=%0d want 1/10/cafef00d/0", a1, grant_q[0], m1.rdat, to_cnt); end
        // Ack landing on the timeout edge: the bus response wins
        clear_mon();
        resp_lat = 16;
        set_m0(1'b1, 1'b0, 32'h84, 32'h2, 1);
        m0.cs = 1'b1;
        wait_pulses(1, 60, ok);
        checks++; if (!ok || a0 != 1 || e0 != 0 || to_cnt != 0 || len_q[0] != 16) begin errors++; $display("FAIL wd_race: a0=%0d e0=%0d to=%0d len=%0d want 1/0/0/16", a0, e0, to_cnt, len_q[0]); end
    endtask

    task automatic test_invalid_op();
        bit ok;
        clear_mon();
        resp_mode = 0; resp_lat = 1;
        set_m1(1'b1, 1'b1, 32'h44, 32'h0, 1);
        m1.cs = 1'b1;
        tick();
        checks++; if (m1.err !== 1'b1 || m1.ack !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL inv_pulse: err=%b ack=%b grant=%b want 1/0/00", m1.err, m1.ack, grant); end
        repeat (3) tick();
        checks++; if (grant_q.size() != 0 || e1 != 1) begin errors++; $display("FAIL inv_bus: cs_xfers=%0d e1=%0d want 0/1", grant_q.size(), e1); end
        clear_mon();
        set_m0(1'b1, 1'b0, 32'h4, 32'h9, 1);
        set_m1(1'b0, 1'b1, 32'h8, 32'h0, 1);
        m0.cs = 1'b1; m1.cs = 1'b1;
        wait_pulses(2, 60, ok);
        checks++; if (!ok || grant_q[0] !== 2'b01 || grant_q[1] !== 2'b10) begin errors++; $display("FAIL inv_last_grant: g0=%b g1=%b want 01/10", grant_q[0], grant_q[1]); end
    endtask

    task automatic test_reset_mid_transfer();
        bit ok;
        clear_mon();
        resp_mode = 0; resp_lat = 5;
        set_m0(1'b1, 1'b0, 32'h50, 32'h77, 1);
        m0.cs = 1'b1;
        repeat (2) tick();
        checks++; if (cpu.cs !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: cs=%b want 1", cpu.cs); end
        ponrst_n = 1'b0;
        #1;
        checks++; if (cpu.cs !== 1'b0 || grant !== 2'b00 || cpu.addr !== 32'd0 || cpu.wdat !== 32'd0 || cpu.write !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: cs=%b grant=%b addr=%h wdat=%h want 0", cpu.cs, grant, cpu.addr, cpu.wdat); end
        repeat (2) tick();
        checks++; if (a0 + e0 + a1 + e1 != 0 || to_cnt != 0) begin errors++; $display("FAIL rst_mid_pulse: pulses=%0d to=%0d want 0", a0 + e0 + a1 + e1, to_cnt); end
        set_m1(1'b0, 1'b1, 32'h60, 32'h0, 1);
        m1.cs = 1'b1;
        resp_lat = 2;
        clear_mon();
        ponrst_n = 1'b1;
        wait_pulses(2, 60, ok);
        checks++; if (!ok || grant_q[0] !== 2'b01 || grant_q[1] !== 2'b10) begin errors++; $display("FAIL rst_mid_order: g0=%b g1=%b want 01/10", grant_q[0], grant_q[1]); end
    endtask

    initial begin
        test_reset();
        test_write_path();
        test_tie_after_reset();
        test_fairness();
        test_watchdog();
        test_invalid_op();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

endmodule
